// File: rtl/shared_alu_pkg.sv
// Shared ALU scheduler: common types and constants.
// Imported by the arbiter and the scheduler top.
package shared_alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int ADD_K       = 5;
  localparam int MUL_K       = 3;
  localparam int COND_THRESH = 100;

  localparam logic [15:0] COND_AND_MASK = 16'hFF00;
  localparam logic [15:0] COND_OR_MASK  = 16'h00FF;

  // Widest stage entry the scheduler supports (NREQ <= 32, W <= 8).
  localparam int STG_TAGW = 5;
  localparam int STG_W    = 8;

  typedef struct packed {
    logic                valid;
    logic [STG_TAGW-1:0] tag;
    logic [STG_W-1:0]    op;
    logic [STG_W-1:0]    add;
  } stage_t;

endpackage

// File: rtl/shared_alu_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
// Purely combinational; gnt is one-hot or zero.
module rr_arbiter
  import shared_alu_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int TAGW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TAGW-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [TAGW-1:0] gnt_idx
);

  logic            found;
  logic [TAGW:0]   sum;
  logic [TAGW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (TAGW+1)'(i);
      if (sum >= (TAGW+1)'(NREQ)) begin
        sum = sum - (TAGW+1)'(NREQ);
      end
      idx = sum[TAGW-1:0];
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_alu_sched.sv
// Round-robin scheduler sharing one 2-stage add/mul/select pipe
// among NREQ requesters, with enable-driven drain-to-idle.
module shared_alu_sched
  import shared_alu_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int TAGW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [W-1:0]      rsp_add,
  output logic [W-1:0]      rsp_mul,
  output logic [2*W-1:0]    rsp_cond,
  output logic              busy
);

  localparam int XT = STG_TAGW - TAGW;
  localparam int XW = STG_W - W;

  localparam logic [2*W-1:0] AND_M =
    (2*W)'(COND_AND_MASK >> (2*XW));
  localparam logic [2*W-1:0] OR_M =
    (2*W)'(COND_OR_MASK >> XW);

  state_e state_q, state_d;

  logic [TAGW-1:0] ptr_q, ptr_d;

  stage_t s1_q, s1_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic [W-1:0]    rsp_add_q, rsp_add_d;
  logic [W-1:0]    rsp_mul_q, rsp_mul_d;
  logic [2*W-1:0]  rsp_cond_q, rsp_cond_d;

  logic            adv;
  logic            gnt_en;
  logic [NREQ-1:0] gnt;
  logic [TAGW-1:0] gnt_idx;
  logic [W-1:0]    op_sel;
  logic [W-1:0]    add_sel;
  logic [W-1:0]    s1_op;
  logic [W-1:0]    s1_add;
  logic [TAGW-1:0] s1_tag;
  logic [W-1:0]    mul_s2;
  logic [2*W-1:0]  cond_s2;

  // The whole pipe moves together; a stalled sink freezes both stages.
  assign adv    = !rsp_valid_q || rsp_ready;
  assign gnt_en = (state_q == RUN) && adv;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (gnt_en),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign req_ready = gnt;
  assign op_sel    = req_data[gnt_idx*W +: W];
  assign add_sel   = op_sel + W'(ADD_K);

  assign s1_op  = s1_q.op[W-1:0];
  assign s1_add = s1_q.add[W-1:0];
  assign s1_tag = s1_q.tag[TAGW-1:0];

  assign mul_s2  = s1_add * W'(MUL_K);
  assign cond_s2 = (int'(s1_op) > COND_THRESH)
                 ? ({s1_add, mul_s2} & AND_M)
                 : ({mul_s2, s1_add} | OR_M);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (!s1_q.valid && !rsp_valid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (gnt_idx == TAGW'(NREQ-1))
            ? '0 : gnt_idx + TAGW'(1);
    end
  end

  always_comb begin
    s1_d        = s1_q;
    rsp_valid_d = rsp_valid_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_add_d   = rsp_add_q;
    rsp_mul_d   = rsp_mul_q;
    rsp_cond_d  = rsp_cond_q;
    if (adv) begin
      s1_d.valid  = |gnt;
      s1_d.tag    = {{XT{1'b0}}, gnt_idx};
      s1_d.op     = {{XW{1'b0}}, op_sel};
      s1_d.add    = {{XW{1'b0}}, add_sel};
      rsp_valid_d = s1_q.valid;
      if (s1_q.valid) begin
        rsp_tag_d  = s1_tag;
        rsp_add_d  = s1_add;
        rsp_mul_d  = mul_s2;
        rsp_cond_d = cond_s2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_add_q   <= '0;
      rsp_mul_q   <= '0;
      rsp_cond_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_add_q   <= rsp_add_d;
      rsp_mul_q   <= rsp_mul_d;
      rsp_cond_q  <= rsp_cond_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_add   = rsp_add_q;
  assign rsp_mul   = rsp_mul_q;
  assign rsp_cond  = rsp_cond_q;
  assign busy      = s1_q.valid || rsp_valid_q
                  || (state_q != IDLE);

endmodule

// File: tb/tb_shared_alu_sched.sv
// Scoreboard bench for shared_alu_sched: tests push hand-computed
// responses, a negedge monitor pops and compares on each handshake.
module tb_shared_alu_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_tag;
  logic [7:0]  rsp_add;
  logic [7:0]  rsp_mul;
  logic [15:0] rsp_cond;
  logic        busy;

  shared_alu_sched #(.NREQ(4), .W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_tag  (rsp_tag),
    .rsp_add  (rsp_add),
    .rsp_mul  (rsp_mul),
    .rsp_cond (rsp_cond),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  tag;
    logic [7:0]  add;
    logic [7:0]  mul;
    logic [15:0] cond;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   sb_on = 1'b1;

  always @(posedge clk) cyc++;

  task automatic push(input logic [1:0] t, input logic [7:0] a,
                      input logic [7:0] m, input logic [15:0] c);
    exp_t e;
    e.tag = t; e.add = a; e.mul = m; e.cond = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (rst_n && sb_on && rsp_valid && rsp_ready) begin
      got = {rsp_tag, rsp_add, rsp_mul, rsp_cond};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %h want none", got);
      end else begin
        e = exp_q.pop_front();
        rsp_cyc.push_back(cyc);
        if (got !== e) begin
          failures++;
          $display("FAIL sb_rsp: got %h want %h", got, e);
        end
      end
    end
  end

  // Grant shape: one-hot or zero, and only to valid requesters
  always @(negedge clk) begin
    if (rst_n && (|req_ready)) begin
      checks++;
      if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != 0) begin
        failures++;
        $display("FAIL gnt_shape: got %b want onehot within %b",
                 req_ready, req_valid);
      end
    end
  end

  task automatic xfer_wait(input int n);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) got++;
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout: got %0d want %0d", got, n);
    end
  endtask

  task automatic wait_empty();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    enable    = 1'b0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    apply_reset();
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp", 64'({rsp_valid, busy}), 64'd0);
    check("rst_data", 64'({rsp_tag, rsp_add, rsp_mul, rsp_cond}), 64'd0);

    // 1: single request, then busy falls
    @(posedge clk); #1;
    req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    push(2'd0, 8'd15, 8'd45, 16'h2DFF);
    enable    = 1'b1;
    req_valid = 4'b0001;
    xfer_wait(1);
    @(posedge clk); #1;
    req_valid = '0;
    enable    = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);
    check("t1_busy_low", 64'(busy), 64'd0);

    // 2: fairness, back-to-back with wrap
    apply_reset();
    rsp_cyc.delete();
    for (int r = 0; r < 2; r++) begin
      push(2'd0, 8'd15, 8'd45,  16'h2DFF);
      push(2'd1, 8'd25, 8'd75,  16'h4BFF);
      push(2'd2, 8'd35, 8'd105, 16'h69FF);
      push(2'd3, 8'd45, 8'd135, 16'h87FF);
    end
    enable    = 1'b1;
    req_valid = 4'b1111;
    xfer_wait(8);
    @(posedge clk); #1;
    req_valid = '0;
    wait_empty();
    check("t2_count", 64'(rsp_cyc.size()), 64'd8);
    if (rsp_cyc.size() == 8) begin
      check("t2_no_bubble", 64'(rsp_cyc[7] - rsp_cyc[0]), 64'd7);
    end

    // 3: backpressure with two in flight
    apply_reset();
    rsp_ready = 1'b0;
    req_data  = {8'd0, 8'd100, 8'd255, 8'd101};
    push(2'd0, 8'd106, 8'd62, 16'h6A00);
    push(2'd1, 8'd4,   8'd12, 16'h0400);
    push(2'd2, 8'd105, 8'd59, 16'h3BFF);
    enable    = 1'b1;
    req_valid = 4'b0011;
    xfer_wait(2);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_hold",
            64'({rsp_valid, req_ready, rsp_tag, rsp_add, rsp_mul, rsp_cond}),
            64'({1'b1, 4'b0000, 2'd0, 8'd106, 8'd62, 16'h6A00}));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    xfer_wait(1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_empty();

    // 4: threshold boundary and wrap
    apply_reset();
    req_data = {8'd251, 8'd255, 8'd101, 8'd100};
    push(2'd0, 8'd105, 8'd59, 16'h3BFF);
    push(2'd1, 8'd106, 8'd62, 16'h6A00);
    push(2'd2, 8'd4,   8'd12, 16'h0400);
    push(2'd3, 8'd0,   8'd0,  16'h0000);
    enable    = 1'b1;
    req_valid = 4'b1111;
    xfer_wait(4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_empty();

    // 5: drain; enable drops while the second grant is up
    apply_reset();
    req_data = {8'd80, 8'd70, 8'd60, 8'd50};
    push(2'd0, 8'd55, 8'd165, 16'hA5FF);
    push(2'd1, 8'd65, 8'd195, 16'hC3FF);
    enable    = 1'b1;
    req_valid = 4'b1111;
    xfer_wait(2);
    enable = 1'b0;
    @(negedge clk);
    check("t5_busy_drain", 64'(busy), 64'd1);
    for (int c = 0; c < 3; c++) begin
      check("t5_no_grant", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = '0;
    wait_empty();
    repeat (3) @(negedge clk);
    check("t5_busy_low", 64'(busy), 64'd0);

    // 6: async reset mid-stream, then first grant to 0
    apply_reset();
    sb_on     = 1'b0;
    req_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    enable    = 1'b1;
    req_valid = 4'b1111;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", 64'({req_ready, rsp_valid, busy}), 64'd0);
    check("t6_rst_data", 64'({rsp_tag, rsp_add, rsp_mul, rsp_cond}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    push(2'd0, 8'd15, 8'd45, 16'h2DFF);
    sb_on = 1'b1;
    rst_n = 1'b1;
    begin
      int c = 0;
      for (c = 0; c < 10; c++) begin
        @(negedge clk);
        if (|req_ready) break;
      end
      check("t6_first_gnt", 64'(req_ready), 64'b0001);
    end
    @(posedge clk); #1;
    req_valid = '0;
    enable    = 1'b0;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
